// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin scheduler sharing one CPU_spi master among four
// requesters. Latches the winner's transaction word and SPI mode, strobes the
// master, follows CS through the transfer and reports completion or timeout.
module spi_arbiter #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned STB_LEN   = 2,
  parameter int unsigned TO_START  = 64,
  parameter int unsigned TO_END    = 1024,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  REQ,
  input  logic [63:0] REQ_DATA,
  input  logic [7:0]  REQ_MODE,
  input  logic        CS,
  output logic        START_STB,
  output logic [15:0] TRANSACCION,
  output logic        CKP,
  output logic        CPH,
  output logic [3:0]  GNT,
  output logic [3:0]  DONE,
  output logic        ERR,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_FINISH,
    S_GAP
  } state_t;

  // Terminal counts for the 11-bit phase counter. Counts start at 0 on state
  // entry, so a phase lasting N cycles ends when the counter shows N-1.
  localparam logic [10:0] SETUP_LAST = 11'(SETUP_CYC - 1);
  localparam logic [10:0] STB_LAST   = 11'(STB_LEN - 1);
  localparam logic [10:0] START_LIM  = 11'(TO_START);
  localparam logic [10:0] END_LIM    = 11'(TO_END);
  localparam logic [10:0] GAP_LAST   = (GAP_CYC == 0) ? 11'd0 : 11'(GAP_CYC - 1);
  localparam bit          HAS_GAP    = (GAP_CYC != 0);
  localparam logic [10:0] CNT_MAX    = 11'h7FF;

  state_t      state;
  logic [10:0] cnt;
  logic [10:0] cnt_inc;
  logic [1:0]  ptr;
  logic        cs_q;
  logic        any_req;
  logic [1:0]  winner;

  // CS arrives from the SPI master; one register stage gives a clean copy.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cs_q <= 1'b1;
    end else begin
      cs_q <= CS;
    end
  end

  // Round-robin search: the first set request at or above the pointer, mod 4.
  // Scanning offsets from high to low lets the smallest offset win.
  always_comb begin
    any_req = 1'b0;
    winner  = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (REQ[ptr + 2'(i)]) begin
        any_req = 1'b1;
        winner  = ptr + 2'(i);
      end
    end
  end

  // Phase counter increment that sticks at all-ones rather than wrapping.
  always_comb begin
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 11'd1;
  end

  // Service sequencer: grant, setup hold, strobe, CS tracking, report, gap.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= S_IDLE;
      cnt         <= 11'd0;
      ptr         <= 2'd0;
      START_STB   <= 1'b0;
      TRANSACCION <= 16'h0000;
      CKP         <= 1'b0;
      CPH         <= 1'b0;
      GNT         <= 4'b0000;
      DONE        <= 4'b0000;
      ERR         <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      DONE <= 4'b0000;
      ERR  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            GNT          <= 4'b0001 << winner;
            TRANSACCION  <= REQ_DATA[{winner, 4'b0000} +: 16];
            {CKP, CPH}   <= REQ_MODE[{winner, 1'b0} +: 2];
            ptr          <= winner + 2'd1;
            BUSY         <= 1'b1;
            cnt          <= 11'd0;
            state        <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            START_STB <= 1'b1;
            cnt       <= 11'd0;
            state     <= S_STROBE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_STROBE: begin
          if (cnt == STB_LAST) begin
            START_STB <= 1'b0;
            cnt       <= 11'd0;
            state     <= S_WAIT_LOW;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_WAIT_LOW: begin
          if (!cs_q) begin
            cnt   <= 11'd0;
            state <= S_WAIT_HIGH;
          end else if (cnt == START_LIM) begin
            DONE  <= GNT;
            ERR   <= 1'b1;
            cnt   <= 11'd0;
            state <= S_FINISH;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_WAIT_HIGH: begin
          if (cs_q) begin
            DONE  <= GNT;
            ERR   <= 1'b0;
            cnt   <= 11'd0;
            state <= S_FINISH;
          end else if (cnt == END_LIM) begin
            DONE  <= GNT;
            ERR   <= 1'b1;
            cnt   <= 11'd0;
            state <= S_FINISH;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_FINISH: begin
          GNT <= 4'b0000;
          cnt <= 11'd0;
          if (HAS_GAP) begin
            state <= S_GAP;
          end else begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
        end

        S_GAP: begin
          if (cnt == GAP_LAST) begin
            BUSY  <= 1'b0;
            cnt   <= 11'd0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          START_STB <= 1'b0;
          GNT       <= 4'b0000;
          BUSY      <= 1'b0;
          cnt       <= 11'd0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
